lc3_decode_stage: RTL and testbench



---
 rtl/lc3_pkg.sv | 45 ++++
 rtl/lc3_instr_decoder.sv | 51 +++++
 rtl/lc3_decode_stage.sv | 142 ++++++++++++++
 tb/tb_lc3_decode_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcode values, immediate-width selects and
// the decoded-entry layout buffered by the decode stage.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] EXT_IMM5  = 2'b00;
    localparam logic [1:0] EXT_OFF6  = 2'b01;
    localparam logic [1:0] EXT_OFF9  = 2'b10;
    localparam logic [1:0] EXT_OFF11 = 2'b11;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  opcode;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [10:0] imm_data;
        logic [1:0]  ext_sel;
        logic        imm_used;
        logic        illegal;
    } decoded_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } occ_t;

endpackage

// File: rtl/lc3_instr_decoder.sv
// Combinational LC-3 field decoder; pc is left zero for the caller to fill in.
module lc3_instr_decoder
    import lc3_pkg::*;
(
    input  logic [15:0] instr,
    output decoded_t    dec
);

    // Field extraction plus immediate-width selection by opcode.
    always_comb begin
        dec          = '0;
        dec.pc       = 16'h0000;
        dec.opcode   = instr[15:12];
        dec.dr       = instr[11:9];
        dec.sr1      = instr[8:6];
        dec.sr2      = instr[2:0];
        dec.imm_data = instr[10:0];
        dec.illegal  = (instr[15:12] == OP_RES);
        dec.ext_sel  = EXT_IMM5;
        dec.imm_used = 1'b0;
        case (instr[15:12])
            OP_ADD, OP_AND: begin
                dec.ext_sel  = EXT_IMM5;
                dec.imm_used = instr[5];
            end
            OP_LDR, OP_STR: begin
                dec.ext_sel  = EXT_OFF6;
                dec.imm_used = 1'b1;
            end
            OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: begin
                dec.ext_sel  = EXT_OFF9;
                dec.imm_used = 1'b1;
            end
            OP_JSR: begin
                // JSRR (bit 11 clear) takes its target from a register.
                if (instr[11]) begin
                    dec.ext_sel  = EXT_OFF11;
                    dec.imm_used = 1'b1;
                end else begin
                    dec.ext_sel  = EXT_IMM5;
                    dec.imm_used = 1'b0;
                end
            end
            default: begin
                dec.ext_sel  = EXT_IMM5;
                dec.imm_used = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: decodes at capture into a 2-entry skid buffer with
// valid/ready on both sides and a synchronous flush.
module lc3_decode_stage
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_dr,
    output logic [2:0]  out_sr1,
    output logic [2:0]  out_sr2,
    output logic [10:0] out_imm_data,
    output logic [1:0]  out_ext_sel,
    output logic        out_imm_used,
    output logic        out_illegal
);

    localparam int DEPTH = 2;

    occ_t     state_r;
    occ_t     state_next_s;
    decoded_t dec_s;
    decoded_t entry_s;
    decoded_t mem_r [DEPTH];
    decoded_t head_s;
    logic     head_r;
    logic     tail_r;
    logic     accept_s;
    logic     pop_s;

    lc3_instr_decoder u_decoder (
        .instr (in_instr),
        .dec   (dec_s)
    );

    // Attach the PC to the decoded fields.
    always_comb begin
        entry_s    = dec_s;
        entry_s.pc = in_pc;
    end

    // Ready comes only from registered occupancy, never from out_ready.
    assign in_ready  = (state_r != OCC_TWO);
    assign out_valid = (state_r != OCC_EMPTY);
    assign accept_s  = in_valid && in_ready && !flush;
    assign pop_s     = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Occupancy next-state; flush overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        state_next_s = OCC_ONE;
                    end else begin
                        state_next_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && !pop_s) begin
                        state_next_s = OCC_TWO;
                    end else if (!accept_s && pop_s) begin
                        state_next_s = OCC_EMPTY;
                    end else begin
                        state_next_s = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    if (pop_s) begin
                        state_next_s = OCC_ONE;
                    end else begin
                        state_next_s = OCC_TWO;
                    end
                end
                default: begin
                    state_next_s = OCC_EMPTY;
                end
            endcase
        end
    end

    // Head/tail pointers; both return to slot 0 on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
        end else if (flush) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
        end else begin
            if (pop_s) begin
                head_r <= ~head_r;
            end
            if (accept_s) begin
                tail_r <= ~tail_r;
            end
        end
    end

    // Entry storage; cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (accept_s) begin
            mem_r[tail_r] <= entry_s;
        end
    end

    assign head_s       = mem_r[head_r];
    assign out_pc       = head_s.pc;
    assign out_opcode   = head_s.opcode;
    assign out_dr       = head_s.dr;
    assign out_sr1      = head_s.sr1;
    assign out_sr2      = head_s.sr2;
    assign out_imm_data = head_s.imm_data;
    assign out_ext_sel  = head_s.ext_sel;
    assign out_imm_used = head_s.imm_used;
    assign out_illegal  = head_s.illegal;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Self-checking bench for lc3_decode_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_lc3_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dr;
    logic [2:0]  out_sr1;
    logic [2:0]  out_sr2;
    logic [10:0] out_imm_data;
    logic [1:0]  out_ext_sel;
    logic        out_imm_used;
    logic        out_illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lc3_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_dr       (out_dr),
        .out_sr1      (out_sr1),
        .out_sr2      (out_sr2),
        .out_imm_data (out_imm_data),
        .out_ext_sel  (out_ext_sel),
        .out_imm_used (out_imm_used),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle {pc,opcode,dr,sr1,sr2,imm,sel,used,illegal}
    // computed from the ISA table with plain arithmetic.
    function automatic logic [43:0] expect_fields(input logic [15:0] instr, input logic [15:0] pc);
        int op;
        int sel;
        int used;
        op   = instr / 4096;
        sel  = 0;
        used = 0;
        if (op == 1 || op == 5) begin
            sel = 0; used = (instr / 32) % 2;
        end else if (op == 6 || op == 7) begin
            sel = 1; used = 1;
        end else if (op == 0 || op == 2 || op == 3 || op == 10 || op == 11 || op == 14) begin
            sel = 2; used = 1;
        end else if (op == 4) begin
            if ((instr / 2048) % 2 == 1) begin sel = 3; used = 1; end
            else begin sel = 0; used = 0; end
        end
        return {pc, 4'(op), 3'((instr / 512) % 8), 3'((instr / 64) % 8), 3'(instr % 8),
                11'(instr % 2048), 2'(sel), 1'(used), 1'(op == 13)};
    endfunction

    function automatic logic [43:0] actual_fields();
        return {out_pc, out_opcode, out_dr, out_sr1, out_sr2, out_imm_data,
                out_ext_sel, out_imm_used, out_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 16'h0000; in_pc = 16'h0000;
        tick();
        tick();
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL reset_handshake: got %b want 01", {out_valid, in_ready});
        else pass_cnt++;
        total_cnt++;
        if (actual_fields() !== 44'h0) $display("FAIL reset_fields: got %h want 0", actual_fields());
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [15:0] instrs [5] = '{16'h12BD, 16'h6705, 16'h4FFF, 16'h4080, 16'hD000};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; out_ready = 1'b0;
            in_instr = instrs[i]; in_pc = 16'h3000 + 16'(i);
            tick();
            in_valid = 1'b0;
            total_cnt++;
            if (out_valid !== 1'b1 || actual_fields() !== expect_fields(instrs[i], 16'h3000 + 16'(i)))
                $display("FAIL decode_%h: got v=%b %h want v=1 %h", instrs[i], out_valid,
                         actual_fields(), expect_fields(instrs[i], 16'h3000 + 16'(i)));
            else pass_cnt++;
            out_ready = 1'b1;
            tick();
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL decode_pop: got out_valid %b want 0", out_valid);
            else pass_cnt++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 16'h1001; in_pc = 16'h4001;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_one_ready: got %b want 1", in_ready);
        else pass_cnt++;
        in_instr = 16'h1002; in_pc = 16'h4002;
        tick();
        in_instr = 16'h1003; in_pc = 16'h4003;
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h4001)
                $display("FAIL bp_full: got rdy=%b v=%b pc=%h want rdy=0 v=1 pc=4001", in_ready, out_valid, out_pc);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || actual_fields() !== expect_fields(16'h1002, 16'h4002))
            $display("FAIL bp_pop2: got v=%b %h want v=1 %h", out_valid, actual_fields(), expect_fields(16'h1002, 16'h4002));
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || actual_fields() !== expect_fields(16'h1003, 16'h4003))
            $display("FAIL bp_pop3: got v=%b %h want v=1 %h", out_valid, actual_fields(), expect_fields(16'h1003, 16'h4003));
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic fill_two();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 16'h2111; in_pc = 16'h5000;
        tick();
        in_instr = 16'h3222; in_pc = 16'h5001;
        tick();
    endtask

    task automatic test_flush();
        fill_two();
        flush = 1'b1; in_instr = 16'h5555; in_pc = 16'h5002;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_empty: got %b want 01", {out_valid, in_ready});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_drop: got out_valid %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        fill_two();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL async_reset: got %b want 01", {out_valid, in_ready});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_instr = 16'hE3FF; in_pc = 16'h6000;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || actual_fields() !== expect_fields(16'hE3FF, 16'h6000))
            $display("FAIL reset_resume: got v=%b %h want v=1 %h", out_valid, actual_fields(), expect_fields(16'hE3FF, 16'h6000));
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] q_instr [$];
        logic [15:0] q_pc [$];
        logic        acc;
        logic        pop;
        for (int cyc = 0; cyc < 400; cyc++) begin
            total_cnt++;
            if (out_valid !== (q_instr.size() > 0) || in_ready !== (q_instr.size() < 2))
                $display("FAIL rand_hs cyc %0d: got v=%b rdy=%b want occupancy %0d", cyc, out_valid, in_ready, q_instr.size());
            else pass_cnt++;
            if (q_instr.size() > 0) begin
                total_cnt++;
                if (actual_fields() !== expect_fields(q_instr[0], q_pc[0]))
                    $display("FAIL rand_head cyc %0d: got %h want %h", cyc, actual_fields(), expect_fields(q_instr[0], q_pc[0]));
                else pass_cnt++;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = 16'($urandom);
            in_pc     = 16'($urandom);
            acc = in_valid && (q_instr.size() < 2) && !flush;
            pop = (q_instr.size() > 0) && out_ready;
            if (flush) begin
                q_instr.delete(); q_pc.delete();
            end else begin
                if (pop) begin
                    void'(q_instr.pop_front()); void'(q_pc.pop_front());
                end
                if (acc) begin
                    q_instr.push_back(in_instr); q_pc.push_back(in_pc);
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
